// File: rtl/pc_ctrl.sv
// Program-counter control: boot hold, branch-mispredict recovery, halt/resume,
// shared-SRAM wait and load-use stalls, plus a saturating stall statistic.
module pc_ctrl #(
  parameter int unsigned BOOT_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        load_use,
  input  logic        mem_req,
  input  logic        mem_done,
  input  logic        ex_br_valid,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [15:0] ex_target,
  input  logic [15:0] ex_pc,
  input  logic        ex_halt,
  input  logic        resume,
  output logic [15:0] pc_next,
  output logic        pc_keep,
  output logic        error,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        bubble_idex,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  localparam logic [7:0] BootLast = 8'(BOOT_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] pc_inc;
  logic        mispredict;

  assign pc_inc     = pc + 16'd1;
  assign mispredict = ex_br_valid & (ex_taken ^ ex_pred_taken);

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_next     = pc_inc;
    pc_keep     = 1'b1;
    error       = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    bubble_idex = 1'b0;
    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) state_d = StRun;
        else                        boot_cnt_d = boot_cnt_q + 8'd1;
      end
      StRun: begin
        if (mispredict) begin
          error      = 1'b1;
          pc_keep    = 1'b0;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          pc_next    = ex_taken ? ex_target : ex_pc + 16'd1;
        end else if (ex_halt) begin
          flush_ifid = 1'b1;
          state_d    = StHalt;
        end else if (mem_req) begin
          flush_ifid = 1'b1;
          state_d    = StMemWait;
        end else if (load_use) begin
          bubble_idex = 1'b1;
        end else begin
          pc_keep = 1'b0;
        end
      end
      StMemWait: begin
        if (mem_done) begin
          pc_keep = 1'b0;
          state_d = StRun;
        end else begin
          flush_ifid = 1'b1;
        end
      end
      StHalt: begin
        if (resume) begin
          pc_keep = 1'b0;
          state_d = StRun;
        end else begin
          flush_ifid = 1'b1;
        end
      end
    endcase
  end

  // Saturating count of edges on which the PC was held outside of boot.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_keep && (state_q != StBoot) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter BOOT_WAIT, default 4; cycles PC is held after reset before fetch starts; range 1..255.
REQ-002 clk  in  1  clock; state updates on rising edge; PC register samples pc_next/pc_keep on falling edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 pc  in  16  current PC from PC register.
REQ-005 load_use  in  1  ID instruction reads the destination of the load currently in EX.
REQ-006 mem_req  in  1  MEM stage requests shared instruction/data SRAM.
REQ-007 mem_done  in  1  shared SRAM access complete, valid in MEM_WAIT only.
REQ-008 ex_br_valid  in  1  EX resolves a branch/jump this cycle.
REQ-009 ex_taken, ex_pred_taken  in  1 each  actual and predicted direction.
REQ-010 ex_target, ex_pc  in  16 each  resolved target; PC of the resolving instruction.
REQ-011 ex_halt, resume  in  1 each  halt instruction in EX; external resume pulse.
REQ-012 pc_next  out  16  PC to load; pc_keep  out  1  hold PC; error  out  1  mispredict recovery.
REQ-013 flush_ifid, flush_idex, bubble_idex  out  1 each  pipeline register controls.
REQ-014 state  out  2  BOOT=0, RUN=1, MEM_WAIT=2, HALT=3; stall_cnt  out  16  stall statistic.

Function
REQ-015 Outputs SHALL be combinational from state and inputs; state, boot counter, stall_cnt SHALL be registered on rising clk.
REQ-016 pc_next SHALL default to pc+1, 16-bit, wrapping 0xFFFF -> 0x0000.
REQ-017 BOOT: pc_keep=1, all flush/bubble=0; counter counts BOOT_WAIT cycles, then -> RUN; all other inputs ignored.
REQ-018 RUN priority: mispredict > ex_halt > mem_req > load_use > normal.
REQ-019 Mispredict = ex_br_valid & (ex_taken != ex_pred_taken): error=1, pc_keep=0, flush_ifid=1, flush_idex=1, pc_next = ex_taken ? ex_target : ex_pc+1 (wrapping); state stays RUN.
REQ-020 ex_br_valid with correct prediction SHALL NOT assert error or flushes.
REQ-021 ex_halt (no mispredict): pc_keep=1, flush_ifid=1; -> HALT.
REQ-022 mem_req (no higher-priority event): pc_keep=1, bubble_idex=0, flush_ifid=1; -> MEM_WAIT.
REQ-023 load_use only: pc_keep=1, bubble_idex=1, IF/ID held (no flush); one cycle per asserted cycle; state stays RUN.
REQ-024 Normal: pc_keep=0, pc_next=pc+1, all flush/bubble=0.
REQ-025 MEM_WAIT: pc_keep=1, flush_ifid=1 each cycle until mem_done; on mem_done cycle pc_keep=0, pc_next=pc+1, -> RUN; load_use and ex_br_valid ignored in MEM_WAIT.
REQ-026 HALT: pc_keep=1, flush_ifid=1; resume=1 -> RUN with pc_keep=0, pc_next=pc+1 that cycle.
REQ-027 stall_cnt SHALL increment once per rising edge where pc_keep=1 and state!=BOOT; saturates at 0xFFFF.
REQ-028 error SHALL be 0 in every state other than RUN.

Reset
REQ-029 rst=0 SHALL immediately force state=BOOT, boot counter=0, stall_cnt=0, independent of clk.
REQ-030 During reset: pc_keep=1, error=0, flush/bubble=0, pc_next=pc+1.
REQ-031 Reset asserted mid-MEM_WAIT or mid-HALT SHALL abandon the operation; after release full BOOT_WAIT sequence repeats.

Verification
REQ-032 Release rst, BOOT_WAIT=4 -> pc_keep=1 for exactly 4 rising edges, state=RUN on 5th cycle, pc_next=pc+1.
REQ-033 RUN, pc=0x0010, ex_br_valid=1, ex_taken=1, ex_pred_taken=0, ex_target=0x0040, load_use=1 -> error=1, pc_next=0x0040, flush_ifid=flush_idex=1, bubble_idex=0.
REQ-034 RUN, mem_req=1, mem_done after 3 cycles -> state=MEM_WAIT, pc_keep=1 for 3 cycles, then pc_keep=0, state=RUN, stall_cnt=3.
REQ-035 RUN, load_use=1 one cycle -> pc_keep=1, bubble_idex=1, flush_ifid=0; next cycle normal, stall_cnt+1.
REQ-036 Not-taken mispredict with ex_pc=0xFFFF -> pc_next=0x0000, error=1.
REQ-037 ex_halt, then rst=0 asynchronously mid-HALT -> state=BOOT immediately, stall_cnt=0; resume before reset release ignored.
